// File: rtl/sid_pkg.sv
// Shared register map, voice constants and bus bit positions for the SID register interface.
package sid_pkg;

    localparam logic [2:0] REG_FREQ_LO  = 3'd0;
    localparam logic [2:0] REG_FREQ_HI  = 3'd1;
    localparam logic [2:0] REG_PW_LO    = 3'd2;
    localparam logic [2:0] REG_PW_HI    = 3'd3;
    localparam logic [2:0] REG_ATK      = 3'd4;
    localparam logic [2:0] REG_SUS      = 3'd5;
    localparam logic [2:0] REG_WAV      = 3'd6;

    localparam logic [2:0] REG_FC_LO    = 3'd0;
    localparam logic [2:0] REG_FC_HI    = 3'd1;
    localparam logic [2:0] REG_RES_FILT = 3'd2;
    localparam logic [2:0] REG_MODE_VOL = 3'd3;

    localparam logic [1:0] VOICE_FILT   = 2'd3;

    localparam int STRB_BIT = 7;
    localparam int RD_BIT   = 5;
    localparam int GATE_BIT = 0;

    // Voice registers live at addr 0..6 of any oscillator voice; voice 3 is never an oscillator.
    function automatic logic voice_reg_mapped(input logic [1:0] voice, input logic [2:0] addr,
                                              input int num_voices);
        return (int'(voice) < num_voices) && (voice != VOICE_FILT) && (addr != 3'd7);
    endfunction

    function automatic logic filt_reg_mapped(input logic [1:0] voice, input logic [2:0] addr);
        return (voice == VOICE_FILT) && (addr[2] == 1'b0);
    endfunction

endpackage

// File: rtl/sid_sync_edge.sv
// Bus synchronizer for the 16 host pins plus write-strobe rising-edge detect.
// The armed flag blocks a strobe that is already high when reset releases.
module sid_sync_edge
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_ui,
    input  logic [7:0] i_uio,
    output logic [1:0] o_voice,
    output logic [2:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_rd,
    output logic       o_strb,
    output logic       o_wr_edge
);

    logic [15:0]            r_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_strb_d;
    logic                   r_armed;
    logic [15:0]            w_bus;

    assign w_bus     = r_sync[SYNC_STAGES-1];
    assign o_strb    = w_bus[8+STRB_BIT];
    assign o_rd      = w_bus[8+RD_BIT];
    assign o_voice   = w_bus[12:11];
    assign o_addr    = w_bus[10:8];
    assign o_data    = w_bus[7:0];
    assign o_wr_edge = o_strb & ~r_strb_d & r_armed;

    // Whole-bus flop chain keeps addr/data aligned with the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 16'h0000;
            end
        end else begin
            r_sync[0] <= {i_ui, i_uio};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // r_fill marks when the chain holds real pin samples rather than reset zeros,
    // so a reset-cleared zero cannot arm the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill   <= '0;
            r_strb_d <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_strb_d <= o_strb;
            if (r_fill[SYNC_STAGES-1] && !o_strb) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sid_reg_if.sv
// SID host register-write responder: decodes synchronized writes into the voice/filter register file.
// Defining SID_REG_READBACK_EN adds a registered readback path on uio_out/uio_oe.
module sid_reg_if
    import sid_pkg::*;
#(
    parameter int NUM_VOICES  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ui_in,
    input  logic [7:0]              uio_in,
    output logic [7:0]              uio_out,
    output logic [7:0]              uio_oe,
    output logic [16*NUM_VOICES-1:0] freq_o,
    output logic [12*NUM_VOICES-1:0] pw_o,
    output logic [8*NUM_VOICES-1:0]  atk_o,
    output logic [8*NUM_VOICES-1:0]  sus_o,
    output logic [8*NUM_VOICES-1:0]  wav_o,
    output logic [NUM_VOICES-1:0]    gate_on_o,
    output logic [10:0]             fc_o,
    output logic [7:0]              res_filt_o,
    output logic [7:0]              mode_vol_o,
    output logic                    wr_pulse_o,
    output logic [1:0]              wr_voice_o,
    output logic [2:0]              wr_addr_o,
    output logic                    bad_addr_o
);

    logic [1:0] w_voice;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic       w_rd;
    logic       w_strb;
    logic       w_wr_edge;
    logic       w_voice_hit;
    logic       w_filt_hit;
    logic       w_bad;
    logic [NUM_VOICES-1:0] w_gate_rise;

    logic [7:0] r_freq_lo [NUM_VOICES];
    logic [7:0] r_freq_hi [NUM_VOICES];
    logic [7:0] r_pw_lo   [NUM_VOICES];
    logic [3:0] r_pw_hi   [NUM_VOICES];
    logic [7:0] r_atk     [NUM_VOICES];
    logic [7:0] r_sus     [NUM_VOICES];
    logic [7:0] r_wav     [NUM_VOICES];
    logic [2:0] r_fc_lo;
    logic [7:0] r_fc_hi;
    logic [7:0] r_res_filt;
    logic [7:0] r_mode_vol;
    logic       r_wr_pulse;
    logic [1:0] r_wr_voice;
    logic [2:0] r_wr_addr;
    logic       r_bad_addr;
    logic [NUM_VOICES-1:0] r_gate_on;

    sid_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .i_ui      (ui_in),
        .i_uio     (uio_in),
        .o_voice   (w_voice),
        .o_addr    (w_addr),
        .o_data    (w_data),
        .o_rd      (w_rd),
        .o_strb    (w_strb),
        .o_wr_edge (w_wr_edge)
    );

    assign w_voice_hit = voice_reg_mapped(w_voice, w_addr, NUM_VOICES);
    assign w_filt_hit  = filt_reg_mapped(w_voice, w_addr);
    assign w_bad       = ~w_voice_hit & ~w_filt_hit;

    // Gate 0->1 detection compares against the value held before this write commits.
    always_comb begin
        w_gate_rise = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_gate_rise[v] = w_wr_edge && w_voice_hit && (int'(w_voice) == v) &&
                             (w_addr == REG_WAV) && !r_wav[v][GATE_BIT] && w_data[GATE_BIT];
        end
    end

    // Voice register file commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_freq_lo[v] <= 8'h00;
                r_freq_hi[v] <= 8'h00;
                r_pw_lo[v]   <= 8'h00;
                r_pw_hi[v]   <= 4'h0;
                r_atk[v]     <= 8'h00;
                r_sus[v]     <= 8'h00;
                r_wav[v]     <= 8'h00;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_wr_edge && w_voice_hit && (int'(w_voice) == v)) begin
                    case (w_addr)
                        REG_FREQ_LO: r_freq_lo[v] <= w_data;
                        REG_FREQ_HI: r_freq_hi[v] <= w_data;
                        REG_PW_LO:   r_pw_lo[v]   <= w_data;
                        REG_PW_HI:   r_pw_hi[v]   <= w_data[3:0];
                        REG_ATK:     r_atk[v]     <= w_data;
                        REG_SUS:     r_sus[v]     <= w_data;
                        REG_WAV:     r_wav[v]     <= w_data;
                        default:     ;
                    endcase
                end
            end
        end
    end

    // Filter bank commit plus write status and gate pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc_lo    <= 3'b000;
            r_fc_hi    <= 8'h00;
            r_res_filt <= 8'h00;
            r_mode_vol <= 8'h00;
            r_wr_pulse <= 1'b0;
            r_wr_voice <= 2'd0;
            r_wr_addr  <= 3'd0;
            r_bad_addr <= 1'b0;
            r_gate_on  <= '0;
        end else begin
            r_wr_pulse <= w_wr_edge;
            r_gate_on  <= w_gate_rise;
            if (w_wr_edge) begin
                r_wr_voice <= w_voice;
                r_wr_addr  <= w_addr;
            end
            if (w_wr_edge && w_bad) begin
                r_bad_addr <= 1'b1;
            end
            if (w_wr_edge && w_filt_hit) begin
                case (w_addr)
                    REG_FC_LO:    r_fc_lo    <= w_data[2:0];
                    REG_FC_HI:    r_fc_hi    <= w_data;
                    REG_RES_FILT: r_res_filt <= w_data;
                    REG_MODE_VOL: r_mode_vol <= w_data;
                    default:      ;
                endcase
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
        assign freq_o[16*v +: 16] = {r_freq_hi[v], r_freq_lo[v]};
        assign pw_o[12*v +: 12]   = {r_pw_hi[v], r_pw_lo[v]};
        assign atk_o[8*v +: 8]    = r_atk[v];
        assign sus_o[8*v +: 8]    = r_sus[v];
        assign wav_o[8*v +: 8]    = r_wav[v];
    end

    assign gate_on_o  = r_gate_on;
    assign fc_o       = {r_fc_hi, r_fc_lo};
    assign res_filt_o = r_res_filt;
    assign mode_vol_o = r_mode_vol;
    assign wr_pulse_o = r_wr_pulse;
    assign wr_voice_o = r_wr_voice;
    assign wr_addr_o  = r_wr_addr;
    assign bad_addr_o = r_bad_addr;

`ifdef SID_REG_READBACK_EN
    logic       w_rd_active;
    logic [7:0] w_rd_data;
    logic [7:0] r_rd_data;
    logic [7:0] r_rd_oe;

    assign w_rd_active = w_rd & ~w_strb;

    // Readback mux; unmapped targets read zero.
    always_comb begin
        w_rd_data = 8'h00;
        if (w_filt_hit) begin
            case (w_addr)
                REG_FC_LO:    w_rd_data = {5'b00000, r_fc_lo};
                REG_FC_HI:    w_rd_data = r_fc_hi;
                REG_RES_FILT: w_rd_data = r_res_filt;
                REG_MODE_VOL: w_rd_data = r_mode_vol;
                default:      w_rd_data = 8'h00;
            endcase
        end else if (w_voice_hit) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (int'(w_voice) == v) begin
                    case (w_addr)
                        REG_FREQ_LO: w_rd_data = r_freq_lo[v];
                        REG_FREQ_HI: w_rd_data = r_freq_hi[v];
                        REG_PW_LO:   w_rd_data = r_pw_lo[v];
                        REG_PW_HI:   w_rd_data = {4'h0, r_pw_hi[v]};
                        REG_ATK:     w_rd_data = r_atk[v];
                        REG_SUS:     w_rd_data = r_sus[v];
                        REG_WAV:     w_rd_data = r_wav[v];
                        default:     w_rd_data = 8'h00;
                    endcase
                end else begin
                    w_rd_data = w_rd_data;
                end
            end
        end else begin
            w_rd_data = 8'h00;
        end
    end

    // Registered readback drive; released the cycle after the read request or strobe changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= 8'h00;
            r_rd_oe   <= 8'h00;
        end else begin
            r_rd_data <= w_rd_active ? w_rd_data : 8'h00;
            r_rd_oe   <= w_rd_active ? 8'hFF : 8'h00;
        end
    end

    assign uio_out = r_rd_data;
    assign uio_oe  = r_rd_oe;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule
